// File: rtl/conv2d_stream_kxk.sv
// -----------------------------------------------------------------------------
// conv2d_stream_kxk
//   Streaming KxK 2-D convolution on a raster AXI-Stream pixel stream.
//   Internal line buffers build the KxK window, signed run-time coefficients
//   (shadow bank copied to the active bank on the first beat of each frame)
//   weight it, and the sum is arithmetically shifted and saturated to an
//   unsigned PIXEL_W-bit result. Only fully populated windows produce output.
//
//   Optional build macro: ABS_OUTPUT_EN
//     defined   : negative shifted sums are output as their magnitude
//     undefined : negative shifted sums clamp to 0
//
// Ports
//   s00_axis_aclk     clock for the whole block
//   s00_axis_aresetn  asynchronous active-low reset
//   s00_axis_t*       input pixel stream (pixel in low PIXEL_W bits of tdata)
//   m00_axis_t*       output pixel stream (zero-extended result)
//   coef_wr_en/addr/data  shadow coefficient write port (row-major index)
//   frame_err         sticky flag: input tlast seen off a line end
//   frame_err_clr     clears frame_err (a simultaneous new error wins)
// -----------------------------------------------------------------------------
module conv2d_stream_kxk #(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int PIXEL_W            = 8,
    parameter int COEF_W             = 8,
    parameter int KERNEL_SIZE        = 3,
    parameter int IMG_WIDTH          = 640,
    parameter int OUT_SHIFT          = 0
) (
    input  logic                          s00_axis_aclk,
    input  logic                          s00_axis_aresetn,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                          s00_axis_tvalid,
    output logic                          s00_axis_tready,
    input  logic                          s00_axis_tlast,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic                          m00_axis_tvalid,
    input  logic                          m00_axis_tready,
    output logic                          m00_axis_tlast,
    input  logic                          coef_wr_en,
    input  logic [4:0]                    coef_addr,
    input  logic [COEF_W-1:0]             coef_data,
    output logic                          frame_err,
    input  logic                          frame_err_clr
);

    localparam int K      = KERNEL_SIZE;
    localparam int KK     = K * K;
    localparam int KA_W   = $clog2(KK);
    localparam int PROD_W = PIXEL_W + COEF_W + 1;
    localparam int ACC_W  = PROD_W + $clog2(KK);
    localparam int COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W  = $clog2(K);
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIXEL_W) - 1);

    // Laplacian default: centre = K*K-1, every other tap = -1
    function automatic logic signed [COEF_W-1:0] default_coef(input int idx);
        if (idx == (KK - 1) / 2) begin
            return COEF_W'(KK - 1);
        end else begin
            return {COEF_W{1'b1}};
        end
    endfunction

    logic                     run_r;
    logic                     ce_s;
    logic                     accept_s;
    logic [PIXEL_W-1:0]       pix_s;
    logic                     unused_tdata_s;

    logic signed [COEF_W-1:0] shadow_r [KK];
    logic signed [COEF_W-1:0] active_r [KK];
    logic                     first_beat_r;

    logic [PIXEL_W-1:0]       lb_r      [K-1][IMG_WIDTH];
    logic [PIXEL_W-1:0]       col_pix_s [K];
    logic [PIXEL_W-1:0]       win_r     [K][K];
    logic [COL_W-1:0]         col_r;
    logic [ROW_W-1:0]         row_r;
    logic                     win_valid_s;
    logic                     at_line_end_s;
    logic                     valid_s1_r;
    logic                     last_s1_r;
    logic                     frame_err_r;

    logic signed [PROD_W-1:0] prod_s;
    logic signed [ACC_W-1:0]  prod_ext_s;
    logic signed [ACC_W-1:0]  sum_s;
    logic signed [ACC_W-1:0]  sum_r;
    logic                     valid_s2_r;
    logic                     last_s2_r;

    logic signed [ACC_W-1:0]  shifted_s;
    logic signed [ACC_W-1:0]  mag_s;
    logic [PIXEL_W-1:0]       res_s;
    logic [C_AXIS_TDATA_WIDTH-1:0] tdata_r;
    logic                     tvalid_r;
    logic                     tlast_r;

    // Input ready is held low while in reset and for the first cycle after it
    assign ce_s            = ~tvalid_r | m00_axis_tready;
    assign s00_axis_tready = ce_s & run_r;
    assign accept_s        = s00_axis_tvalid & s00_axis_tready;
    assign pix_s           = s00_axis_tdata[PIXEL_W-1:0];
    assign unused_tdata_s  = ^s00_axis_tdata[C_AXIS_TDATA_WIDTH-1:PIXEL_W];

    assign at_line_end_s = (col_r == COL_W'(IMG_WIDTH - 1));
    assign win_valid_s   = (col_r >= COL_W'(K - 1)) && (row_r == ROW_W'(K - 1));

    assign m00_axis_tdata  = tdata_r;
    assign m00_axis_tvalid = tvalid_r;
    assign m00_axis_tlast  = tlast_r;
    assign frame_err       = frame_err_r;

    // Post-reset run enable
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    // Coefficient banks: shadow written by host, active loaded on first beat of a frame
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            for (int i = 0; i < KK; i++) begin
                shadow_r[i] <= default_coef(i);
                active_r[i] <= default_coef(i);
            end
            first_beat_r <= 1'b1;
        end else begin
            if (coef_wr_en && (coef_addr < 5'(KK))) begin
                shadow_r[coef_addr[KA_W-1:0]] <= coef_data;
            end
            if (accept_s) begin
                // Copy sees the pre-write shadow, so a coincident write waits a frame
                if (first_beat_r) begin
                    for (int i = 0; i < KK; i++) begin
                        active_r[i] <= shadow_r[i];
                    end
                end
                first_beat_r <= s00_axis_tlast;
            end
        end
    end

    // Line buffers: line 0 is the previous line, line K-2 the oldest
    always_ff @(posedge s00_axis_aclk) begin
        if (accept_s) begin
            lb_r[0][col_r] <= pix_s;
            for (int i = 1; i < K - 1; i++) begin
                lb_r[i][col_r] <= lb_r[i-1][col_r];
            end
        end
    end

    // New window column, top row (oldest line) first, current pixel last
    always_comb begin
        for (int r = 0; r < K - 1; r++) begin
            col_pix_s[r] = lb_r[K-2-r][col_r];
        end
        col_pix_s[K-1] = pix_s;
    end

    // Stage 1: window shift, raster counters, frame-length checking
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_r[r][c] <= {PIXEL_W{1'b0}};
                end
            end
            col_r       <= {COL_W{1'b0}};
            row_r       <= {ROW_W{1'b0}};
            valid_s1_r  <= 1'b0;
            last_s1_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            if (ce_s) begin
                if (accept_s) begin
                    for (int r = 0; r < K; r++) begin
                        for (int c = 0; c < K - 1; c++) begin
                            win_r[r][c] <= win_r[r][c+1];
                        end
                        win_r[r][K-1] <= col_pix_s[r];
                    end
                    valid_s1_r <= win_valid_s;
                    last_s1_r  <= s00_axis_tlast & win_valid_s;
                    if (s00_axis_tlast) begin
                        col_r <= {COL_W{1'b0}};
                        row_r <= {ROW_W{1'b0}};
                    end else if (at_line_end_s) begin
                        col_r <= {COL_W{1'b0}};
                        // Row only needs to know "at least K-1 lines seen"
                        row_r <= (row_r == ROW_W'(K - 1)) ? row_r : row_r + ROW_W'(1);
                    end else begin
                        col_r <= col_r + COL_W'(1);
                    end
                end else begin
                    valid_s1_r <= 1'b0;
                    last_s1_r  <= 1'b0;
                end
            end
            if (accept_s && s00_axis_tlast && !at_line_end_s) begin
                frame_err_r <= 1'b1;
            end else if (frame_err_clr) begin
                frame_err_r <= 1'b0;
            end else begin
                frame_err_r <= frame_err_r;
            end
        end
    end

    // Stage 2 datapath: signed sum of products over the zero-extended window
    always_comb begin
        sum_s      = {ACC_W{1'b0}};
        prod_s     = {PROD_W{1'b0}};
        prod_ext_s = {ACC_W{1'b0}};
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                prod_s     = $signed({1'b0, win_r[r][c]}) * active_r[r*K+c];
                prod_ext_s = prod_s;
                sum_s      = sum_s + prod_ext_s;
            end
        end
    end

    // Stage 2 register
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            sum_r      <= {ACC_W{1'b0}};
            valid_s2_r <= 1'b0;
            last_s2_r  <= 1'b0;
        end else if (ce_s) begin
            sum_r      <= sum_s;
            valid_s2_r <= valid_s1_r;
            last_s2_r  <= last_s1_r;
        end
    end

    // Stage 3 datapath: normalise, optional magnitude, saturate to pixel range
    always_comb begin
        shifted_s = sum_r >>> OUT_SHIFT;
`ifdef ABS_OUTPUT_EN
        if (shifted_s[ACC_W-1]) begin
            mag_s = -shifted_s;
        end else begin
            mag_s = shifted_s;
        end
`else
        mag_s = shifted_s;
`endif
        if (mag_s[ACC_W-1]) begin
            res_s = {PIXEL_W{1'b0}};
        end else if (mag_s > PIX_MAX) begin
            res_s = {PIXEL_W{1'b1}};
        end else begin
            res_s = mag_s[PIXEL_W-1:0];
        end
    end

    // Stage 3 output register; holds while the sink stalls
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            tdata_r  <= {C_AXIS_TDATA_WIDTH{1'b0}};
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
        end else if (ce_s) begin
            tdata_r  <= {{(C_AXIS_TDATA_WIDTH-PIXEL_W){1'b0}}, res_s};
            tvalid_r <= valid_s2_r;
            tlast_r  <= last_s2_r;
        end
    end

endmodule

// File: tb/tb_conv2d_stream_kxk.sv
module tb_conv2d_stream_kxk;

    localparam int W = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic        coef_wr_en;
    logic [4:0]  coef_addr;
    logic [7:0]  coef_data;
    logic        frame_err;
    logic        frame_err_clr;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;
    exp_t q[$];

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;
    int n_last = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int first_valid_cyc = 0;
    bit lat_seen = 1'b1;
    int ready_mode = 1;
    logic [7:0] pix [0:63];
    int mk [0:8];

    conv2d_stream_kxk #(
        .C_AXIS_TDATA_WIDTH(32), .PIXEL_W(8), .COEF_W(8),
        .KERNEL_SIZE(3), .IMG_WIDTH(W), .OUT_SHIFT(0)
    ) dut (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
        .s00_axis_tdata(s_tdata), .s00_axis_tvalid(s_tvalid),
        .s00_axis_tready(s_tready), .s00_axis_tlast(s_tlast),
        .m00_axis_tdata(m_tdata), .m00_axis_tvalid(m_tvalid),
        .m00_axis_tready(m_tready), .m00_axis_tlast(m_tlast),
        .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_data(coef_data),
        .frame_err(frame_err), .frame_err_clr(frame_err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        case (ready_mode)
            0:       m_tready <= 1'b0;
            1:       m_tready <= 1'b1;
            default: m_tready <= 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Output monitor: handshake values are stable from negedge until the next posedge
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_n === 1'b1 && m_tvalid === 1'b1) begin
            if (!lat_seen) begin
                lat_seen = 1'b1;
                first_valid_cyc = cyc;
            end
            if (m_tready === 1'b1) begin
                if (m_tlast === 1'b1) n_last++;
                if (q.size() == 0) begin
                    check("sb_extra_beat", q.size(), 1);
                end else begin
                    e = q.pop_front();
                    check("out_data", m_tdata, {24'd0, e.d});
                    check("out_last", {31'd0, m_tlast}, {31'd0, e.l});
                end
            end
        end
    end

    task automatic push_frame(input int n);
        int s;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            int r, c;
            r = i / W;
            c = i % W;
            if (r >= 2 && c >= 2) begin
                s = 0;
                for (int a = 0; a < 3; a++)
                    for (int b = 0; b < 3; b++)
                        s += mk[a*3+b] * int'(pix[(r-2+a)*W + (c-2+b)]);
`ifdef ABS_OUTPUT_EN
                if (s < 0) s = -s;
`endif
                if (s < 0) s = 0;
                if (s > 255) s = 255;
                e.d = 8'(s);
                e.l = (i == n - 1);
                q.push_back(e);
            end
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l);
        int n;
        logic ok;
        s_tdata = {24'd0, d};
        s_tlast = l;
        s_tvalid = 1'b1;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 2000) begin
            @(negedge clk);
            #1;
            ok = s_tready;
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        if (!ok) check("accept_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic send_frame(input int n);
        for (int i = 0; i < n; i++) send_beat(pix[i], i == n - 1);
    endtask

    task automatic wr_coef(input logic [4:0] a, input logic [7:0] d);
        coef_wr_en = 1'b1;
        coef_addr = a;
        coef_data = d;
        @(posedge clk);
        #1;
        coef_wr_en = 1'b0;
    endtask

    task automatic load_kernel();
        int v;
        for (int i = 0; i < 9; i++) begin
            v = mk[i];
            wr_coef(5'(i), v[7:0]);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic set_identity();
        for (int i = 0; i < 9; i++) mk[i] = (i == 4) ? 1 : 0;
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int acc10;
        int last0;
        int n;
        rst_n = 1'b0;
        s_tdata = 32'd0;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        coef_wr_en = 1'b0;
        coef_addr = 5'd0;
        coef_data = 8'd0;
        frame_err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("rst_tdata", m_tdata, 32'd0);
        check("rst_tlast", {31'd0, m_tlast}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_tready", {31'd0, s_tready}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("ready_after_reset", {31'd0, s_tready}, 32'd1);

        // Default Laplacian on a flat frame, then with a bright centre pixel
        for (int i = 0; i < 9; i++) mk[i] = (i == 4) ? 8 : -1;
        for (int i = 0; i < 16; i++) pix[i] = 8'd100;
        push_frame(16);
        send_frame(16);
        drain();
        pix[5] = 8'd200;
        push_frame(16);
        send_frame(16);
        drain();

        // Stall the output, then reset mid-frame
        ready_mode = 0;
        for (int i = 0; i < 11; i++) send_beat(pix[i], 1'b0);
        n = 0;
        while (m_tvalid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("stall_valid", {31'd0, m_tvalid}, 32'd1);
        check("stall_data", m_tdata, 32'd255);
        repeat (3) @(posedge clk);
        #1;
        check("stall_hold_valid", {31'd0, m_tvalid}, 32'd1);
        check("stall_hold_data", m_tdata, 32'd255);
        check("stall_ready", {31'd0, s_tready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("async_rst_tdata", m_tdata, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        push_frame(16);
        send_frame(16);
        drain();

        // Identity kernel on a ramp, with latency measurement
        set_identity();
        load_kernel();
        for (int i = 0; i < 16; i++) pix[i] = 8'(i);
        push_frame(16);
        last0 = n_last;
        lat_seen = 1'b0;
        acc10 = 0;
        for (int i = 0; i < 16; i++) begin
            send_beat(pix[i], i == 15);
            if (i == 10) acc10 = acc_cyc;
        end
        drain();
        check("latency", first_valid_cyc - acc10, 32'd3);
        check("identity_tlast_count", n_last - last0, 32'd1);

        // All-ones kernel: in range, then saturated
        for (int i = 0; i < 9; i++) mk[i] = 1;
        load_kernel();
        for (int i = 0; i < 16; i++) pix[i] = 8'd10;
        push_frame(16);
        send_frame(16);
        drain();
        for (int i = 0; i < 16; i++) pix[i] = 8'd80;
        push_frame(16);
        send_frame(16);
        drain();

        // Random kernel, random pixels, random sink backpressure, 3 back-to-back frames
        for (int i = 0; i < 9; i++) mk[i] = int'($urandom_range(0, 6)) - 3;
        load_kernel();
        ready_mode = 2;
        last0 = n_last;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 16; i++) pix[i] = 8'($urandom_range(0, 255));
            push_frame(16);
            send_frame(16);
        end
        drain();
        check("random_tlast_count", n_last - last0, 32'd3);
        ready_mode = 1;
        repeat (2) @(posedge clk);
        #1;

        // Short frame: tlast at pixel 6 (col 2)
        set_identity();
        load_kernel();
        check("err_before", {31'd0, frame_err}, 32'd0);
        for (int i = 0; i < 16; i++) pix[i] = 8'(3 * i + 1);
        push_frame(7);
        send_frame(7);
        repeat (2) @(posedge clk);
        #1;
        check("err_set", {31'd0, frame_err}, 32'd1);
        push_frame(16);
        send_frame(16);
        drain();
        check("err_sticky", {31'd0, frame_err}, 32'd1);
        frame_err_clr = 1'b1;
        send_beat(8'd9, 1'b1);
        frame_err_clr = 1'b0;
        check("err_clr_vs_set", {31'd0, frame_err}, 32'd1);
        frame_err_clr = 1'b1;
        @(posedge clk);
        #1;
        frame_err_clr = 1'b0;
        check("err_cleared", {31'd0, frame_err}, 32'd0);

        // Coefficient writes mid-frame take effect on the next frame only
        for (int i = 0; i < 16; i++) pix[i] = 8'($urandom_range(0, 80));
        push_frame(16);
        for (int i = 0; i < 8; i++) send_beat(pix[i], 1'b0);
        wr_coef(5'd4, 8'd3);
        wr_coef(5'd17, 8'd5);
        wr_coef(5'd9, 8'd7);
        for (int i = 8; i < 16; i++) send_beat(pix[i], i == 15);
        drain();
        mk[4] = 3;
        for (int i = 0; i < 16; i++) pix[i] = 8'($urandom_range(0, 80));
        push_frame(16);
        send_frame(16);
        drain();
        check("final_err_clear", {31'd0, frame_err}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
